// File: rtl/mem_stage_lsu_if.sv
// Bundle between the LSU, the execute stage, writeback and the cache core.
// Handshakes: a request is taken on a rising edge where in_valid and in_ready are
// both high; req_* stay stable while req_cyc is high until req_ack is seen; every
// resp_cyc pulse is answered by a single-cycle resp_ack on the following cycle;
// out_valid holds with the result fields stable while wb_stall is high.
interface mem_stage_lsu_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int TAG_W  = 8
);
  // execute side
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_write;
  logic [1:0]            in_size;
  logic                  in_signed;
  logic [ADDR_W-1:0]     in_addr;
  logic [DATA_W-1:0]     in_wdata;
  logic [TAG_W-1:0]      in_tag;
  // writeback side
  logic                  wb_stall;
  logic                  out_valid;
  logic [DATA_W-1:0]     out_rdata;
  logic [TAG_W-1:0]      out_tag;
  logic [1:0]            out_fault;
  logic                  stall_out;
  // cache-core side
  logic                  req_cyc;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_write;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic [TAG_W-1:0]      req_tag;
  logic                  req_ack;
  logic                  resp_cyc;
  logic [DATA_W-1:0]     resp_data;
  logic                  resp_ack;
  // FSM state for observation: 0 IDLE, 1 REQ, 2 RESP, 3 DONE
  logic [1:0]            dbg_state;

  // LSU side
  modport master (
    input  in_valid, in_write, in_size, in_signed, in_addr, in_wdata, in_tag,
    input  wb_stall, req_ack, resp_cyc, resp_data,
    output in_ready, out_valid, out_rdata, out_tag, out_fault, stall_out,
    output req_cyc, req_addr, req_write, req_wdata, req_be, req_tag, resp_ack,
    output dbg_state
  );

  // environment side (execute, writeback, cache core)
  modport slave (
    output in_valid, in_write, in_size, in_signed, in_addr, in_wdata, in_tag,
    output wb_stall, req_ack, resp_cyc, resp_data,
    input  in_ready, out_valid, out_rdata, out_tag, out_fault, stall_out,
    input  req_cyc, req_addr, req_write, req_wdata, req_be, req_tag, resp_ack,
    input  dbg_state
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Load/store unit for the memory stage: one transaction in flight, byte-lane
// placement for stores, extraction plus sign/zero extension for loads,
// alignment faults and a bus response timeout.
module mem_stage_lsu #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 64,
  parameter int TAG_W       = 8,
  parameter int ALIGN_CHECK = 1,
  parameter int TIMEOUT     = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_stage_lsu_if.master bus
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2, S_DONE = 2'd3} state_t;

  state_t              state, state_nx;
  logic [1:0]          lat_size;
  logic                lat_signed;
  logic [OFF_W-1:0]    lat_off;
  logic [31:0]         tmo_cnt;
  logic                req_write_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [DATA_W-1:0]   req_wdata_q;
  logic [NB-1:0]       req_be_q;
  logic [TAG_W-1:0]    req_tag_q;
  logic                resp_ack_q;
  logic [DATA_W-1:0]   out_rdata_q;
  logic [TAG_W-1:0]    out_tag_q;
  logic [1:0]          out_fault_q;

  logic                accept, in_fault, capture, tmo_hit, tmo_fire, busy;
  int                  nbytes_in, nbits_lat;
  logic [OFF_W-1:0]    in_off;
  logic [NB-1:0]       be_base;
  logic [DATA_W-1:0]   shifted, load_val;
  logic [IDX_W-1:0]    msb_idx;
  logic                sign_bit;

  assign busy     = (state == S_REQ) || (state == S_RESP);
  assign accept   = bus.in_valid && (state == S_IDLE);
  assign capture  = bus.resp_cyc && (((state == S_REQ) && bus.req_ack) || (state == S_RESP));
  assign tmo_hit  = (TIMEOUT != 0) && (tmo_cnt == 32'(TIMEOUT - 1));
  assign tmo_fire = busy && tmo_hit && !capture;

  // Request decode: size check, alignment check and byte-lane placement.
  always_comb begin
    nbytes_in = 32'd1 << bus.in_size;
    in_off    = OFF_W'(bus.in_addr % ADDR_W'(NB));
    in_fault  = (nbytes_in > NB) ||
                ((ALIGN_CHECK != 0) && ((bus.in_addr & ADDR_W'(nbytes_in - 1)) != '0));
    be_base   = '0;
    for (int i = 0; i < NB; i++) be_base[i] = (i < nbytes_in);
  end

  // Load extraction: move the addressed bytes down, then extend above the access width.
  always_comb begin
    nbits_lat = 32'd8 << lat_size;
    msb_idx   = (nbits_lat > DATA_W) ? IDX_W'(DATA_W - 1) : IDX_W'(nbits_lat - 1);
    shifted   = bus.resp_data >> {lat_off, 3'b000};
    sign_bit  = lat_signed && shifted[msb_idx];
    load_val  = '0;
    for (int i = 0; i < DATA_W; i++) load_val[i] = (i < nbits_lat) ? shifted[i] : sign_bit;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // FSM next state; a completing response wins over a timeout in the same cycle.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = in_fault ? S_DONE : S_REQ;
      S_REQ: begin
        if (bus.req_ack && bus.resp_cyc) state_nx = S_DONE;
        else if (tmo_hit)                state_nx = S_DONE;
        else if (bus.req_ack)            state_nx = S_RESP;
      end
      S_RESP: if (bus.resp_cyc || tmo_hit) state_nx = S_DONE;
      S_DONE: if (!bus.wb_stall) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: latch request, count busy cycles, capture result or fault.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_size    <= '0;
      lat_signed  <= 1'b0;
      lat_off     <= '0;
      tmo_cnt     <= '0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      req_tag_q   <= '0;
      resp_ack_q  <= 1'b0;
      out_rdata_q <= '0;
      out_tag_q   <= '0;
      out_fault_q <= 2'd0;
    end else begin
      // stray responses outside REQ/RESP are acknowledged and dropped
      resp_ack_q <= bus.resp_cyc && (capture || (state == S_IDLE) || (state == S_DONE));
      if (busy && (TIMEOUT != 0)) tmo_cnt <= tmo_cnt + 32'd1;
      if (accept) begin
        tmo_cnt    <= '0;
        lat_size   <= bus.in_size;
        lat_signed <= bus.in_signed;
        lat_off    <= in_off;
        if (in_fault) begin
          out_rdata_q <= '0;
          out_tag_q   <= bus.in_tag;
          out_fault_q <= 2'd1;
        end else begin
          req_write_q <= bus.in_write;
          req_addr_q  <= bus.in_addr & ~ADDR_W'(NB - 1);
          req_wdata_q <= bus.in_write ? (bus.in_wdata << {in_off, 3'b000}) : '0;
          req_be_q    <= be_base << in_off;
          req_tag_q   <= bus.in_tag;
        end
      end
      if (capture) begin
        out_rdata_q <= req_write_q ? '0 : load_val;
        out_tag_q   <= req_tag_q;
        out_fault_q <= 2'd0;
      end else if (tmo_fire) begin
        out_rdata_q <= '0;
        out_tag_q   <= req_tag_q;
        out_fault_q <= 2'd2;
      end
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.stall_out = busy;
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_rdata = out_rdata_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_fault = out_fault_q;
  assign bus.req_cyc   = (state == S_REQ);
  assign bus.req_addr  = req_addr_q;
  assign bus.req_write = req_write_q;
  assign bus.req_wdata = req_wdata_q;
  assign bus.req_be    = req_be_q;
  assign bus.req_tag   = req_tag_q;
  assign bus.resp_ack  = resp_ack_q;
  assign bus.dbg_state = state;
endmodule
